// File: rtl/ab_code_solver.sv
// Bulls-and-cows code breaker: proposes 4-digit BCD guesses with distinct digits and
// narrows the search using stored (guess, A, B) feedback, one history entry per cycle.
module ab_code_solver #(
  parameter int unsigned MAX_HIST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        fb_valid,
  input  logic [2:0]  fb_a,
  input  logic [2:0]  fb_b,
  output logic        guess_valid,
  output logic [15:0] guess,
  output logic        busy,
  output logic        solved,
  output logic        fail,
  output logic [3:0]  guess_cnt
);

  localparam int unsigned Depth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StPropose,
    StDone,
    StFail
  } state_e;

  state_e      state_q;
  logic [15:0] cand_q;
  logic [3:0]  idx_q;
  logic [3:0]  hist_cnt_q;
  logic [15:0] hist_g_q [Depth];
  logic [2:0]  hist_a_q [Depth];
  logic [2:0]  hist_b_q [Depth];

  logic        cand_rep;
  logic [2:0]  score_a;
  logic [2:0]  score_common;
  logic [2:0]  score_b;
  logic        score_match;
  logic [15:0] sel_g;
  logic [15:0] cand_next;
  logic        cand_carry;
  logic        cand_last;
  logic [3:0]  fb_sum;
  logic        fb_win;
  logic        fb_illegal;

  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [16:0] r;
    logic        c;
    logic [3:0]  d;
    r = '0;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (d == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    r[16] = c;
    return r;
  endfunction

  always_comb begin
    cand_rep = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (cand_q[4*i +: 4] == cand_q[4*j +: 4]) cand_rep = 1'b1;
      end
    end
  end

  // Both codes have distinct digits, so pairwise matches count the common digits exactly.
  always_comb begin
    sel_g        = hist_g_q[idx_q];
    score_a      = '0;
    score_common = '0;
    for (int i = 0; i < 4; i++) begin
      if (cand_q[4*i +: 4] == sel_g[4*i +: 4]) score_a = score_a + 3'd1;
      for (int j = 0; j < 4; j++) begin
        if (cand_q[4*i +: 4] == sel_g[4*j +: 4]) score_common = score_common + 3'd1;
      end
    end
    score_b     = score_common - score_a;
    score_match = (score_a == hist_a_q[idx_q]) && (score_b == hist_b_q[idx_q]);
  end

  always_comb begin
    {cand_carry, cand_next} = bcd_inc(cand_q);
    cand_last = (cand_q == 16'h9876) || cand_carry;
  end

  always_comb begin
    fb_sum     = {1'b0, fb_a} + {1'b0, fb_b};
    fb_win     = (fb_a == 3'd4) && (fb_b == 3'd0);
    fb_illegal = (fb_a > 3'd4) || (fb_b > 3'd4) || (fb_sum > 4'd4) ||
                 ((fb_a == 3'd4) && (fb_b != 3'd0)) ||
                 ((fb_a == 3'd3) && (fb_b == 3'd1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cand_q     <= '0;
      idx_q      <= '0;
      hist_cnt_q <= '0;
      guess      <= '0;
      guess_cnt  <= '0;
      for (int i = 0; i < Depth; i++) begin
        hist_g_q[i] <= '0;
        hist_a_q[i] <= '0;
        hist_b_q[i] <= '0;
      end
    end else if (start) begin
      state_q    <= StSearch;
      cand_q     <= 16'h0123;
      idx_q      <= '0;
      hist_cnt_q <= '0;
      guess_cnt  <= '0;
    end else begin
      unique case (state_q)
        StSearch: begin
          if (cand_rep || ((idx_q < hist_cnt_q) && !score_match)) begin
            idx_q <= '0;
            if (cand_last) begin
              state_q <= StFail;
            end else begin
              cand_q <= cand_next;
            end
          end else if (idx_q < hist_cnt_q) begin
            idx_q <= idx_q + 4'd1;
          end else begin
            guess     <= cand_q;
            guess_cnt <= guess_cnt + 4'd1;
            state_q   <= StPropose;
          end
        end
        StPropose: begin
          if (fb_valid) begin
            if (fb_win) begin
              state_q <= StDone;
            end else if (fb_illegal || (hist_cnt_q == 4'(MAX_HIST))) begin
              state_q <= StFail;
            end else begin
              hist_g_q[hist_cnt_q] <= guess;
              hist_a_q[hist_cnt_q] <= fb_a;
              hist_b_q[hist_cnt_q] <= fb_b;
              hist_cnt_q           <= hist_cnt_q + 4'd1;
              idx_q                <= '0;
              if (cand_last) begin
                state_q <= StFail;
              end else begin
                cand_q  <= cand_next;
                state_q <= StSearch;
              end
            end
          end
        end
        StIdle, StDone, StFail: begin
          state_q <= state_q;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign guess_valid = (state_q == StPropose);
  assign busy        = (state_q == StSearch) || (state_q == StPropose);
  assign solved      = (state_q == StDone);
  assign fail        = (state_q == StFail);

endmodule

// File: tb/tb_ab_code_solver.sv
// Self-checking bench for ab_code_solver: directed scenarios plus random secrets
// scored against a decimal reference solver.
module tb_ab_code_solver;

  localparam int MaxHist = 8;
  localparam int WaitMax = 30000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        fb_valid = 1'b0;
  logic [2:0]  fb_a = '0;
  logic [2:0]  fb_b = '0;
  logic        guess_valid;
  logic [15:0] guess;
  logic        busy;
  logic        solved;
  logic        fail;
  logic [3:0]  guess_cnt;

  int total = 0;
  int bad   = 0;

  int hist_g[$];
  int hist_a[$];
  int hist_b[$];

  ab_code_solver #(.MAX_HIST(MaxHist)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fb_valid   (fb_valid),
    .fb_a       (fb_a),
    .fb_b       (fb_b),
    .guess_valid(guess_valid),
    .guess      (guess),
    .busy       (busy),
    .solved     (solved),
    .fail       (fail),
    .guess_cnt  (guess_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on 0..9999.
  function automatic int dig(int v, int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic bit distinct(int v);
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (dig(v, i) == dig(v, j)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void score(input int x, input int y, output int a, output int b);
    int common = 0;
    a = 0;
    for (int i = 0; i < 4; i++) begin
      if (dig(x, i) == dig(y, i)) a++;
      for (int j = 0; j < 4; j++) if (dig(x, i) == dig(y, j)) common++;
    end
    b = common - a;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'(dig(v, 3)), 4'(dig(v, 2)), 4'(dig(v, 1)), 4'(dig(v, 0))};
  endfunction

  function automatic int next_cand(int from);
    int a, b;
    bit ok;
    for (int v = from; v <= 9876; v++) begin
      if (distinct(v)) begin
        ok = 1'b1;
        for (int k = 0; k < hist_g.size(); k++) begin
          score(v, hist_g[k], a, b);
          if (a != hist_a[k] || b != hist_b[k]) ok = 1'b0;
        end
        if (ok) return v;
      end
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic give_fb(input int a, input int b);
    fb_valid = 1'b1;
    fb_a     = 3'(a);
    fb_b     = 3'(b);
    tick();
    fb_valid = 1'b0;
    fb_a     = '0;
    fb_b     = '0;
  endtask

  task automatic wait_evt(input string tag);
    bit to = 1'b1;
    for (int i = 0; i < WaitMax; i++) begin
      if (guess_valid || solved || fail) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    chk({tag, "_timeout"}, {31'b0, to}, 32'd0);
  endtask

  task automatic play(input int secret, input string tag);
    int pred, a, b, n;
    hist_g.delete();
    hist_a.delete();
    hist_b.delete();
    do_start();
    pred = next_cand(123);
    n = 1;
    forever begin
      wait_evt(tag);
      if (pred < 0) begin
        chk({tag, "_nocand_fail"}, {31'b0, fail}, 32'd1);
        chk({tag, "_nocand_gv"}, {31'b0, guess_valid}, 32'd0);
        break;
      end
      chk({tag, "_gv"}, {31'b0, guess_valid}, 32'd1);
      chk({tag, "_guess"}, {16'b0, guess}, {16'b0, to_bcd(pred)});
      chk({tag, "_cnt"}, {28'b0, guess_cnt}, 32'(n));
      if (!guess_valid) break;
      score(pred, secret, a, b);
      give_fb(a, b);
      if (a == 4) begin
        chk({tag, "_solved"}, {31'b0, solved}, 32'd1);
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        chk({tag, "_guess_done"}, {16'b0, guess}, {16'b0, to_bcd(pred)});
        chk({tag, "_cnt_done"}, {28'b0, guess_cnt}, 32'(n));
        break;
      end
      if (hist_g.size() == MaxHist) begin
        chk({tag, "_hist_full_fail"}, {31'b0, fail}, 32'd1);
        break;
      end
      hist_g.push_back(pred);
      hist_a.push_back(a);
      hist_b.push_back(b);
      pred = (pred == 9876) ? -1 : next_cand(pred + 1);
      n++;
    end
  endtask

  initial begin
    int secret;

    // Reset state, then stay idle until start.
    #12;
    chk("rst_gv", {31'b0, guess_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_guess", {16'b0, guess}, 32'd0);
    chk("rst_cnt", {28'b0, guess_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    fb_valid = 1'b1;
    tick();
    tick();
    fb_valid = 1'b0;
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_status", {29'b0, guess_valid, solved, fail}, 32'd0);

    // Start latency and secret 0123.
    do_start();
    chk("lat_busy_k1", {31'b0, busy}, 32'd1);
    chk("lat_gv_k1", {31'b0, guess_valid}, 32'd0);
    tick();
    chk("lat_gv_k2", {31'b0, guess_valid}, 32'd1);
    chk("lat_guess_k2", {16'b0, guess}, 32'h0123);
    chk("lat_cnt_k2", {28'b0, guess_cnt}, 32'd1);
    give_fb(4, 0);
    chk("s0123_solved", {31'b0, solved}, 32'd1);
    chk("s0123_busy", {31'b0, busy}, 32'd0);
    chk("s0123_guess", {16'b0, guess}, 32'h0123);
    chk("s0123_cnt", {28'b0, guess_cnt}, 32'd1);
    give_fb(1, 0);
    tick();
    chk("done_hold", {27'b0, solved, fail, busy, guess_valid, 1'b0}, 32'h10);
    chk("done_hold_guess", {16'b0, guess}, 32'h0123);

    // Secret 4567 via the model.
    play(4567, "s4567");

    // No consistent candidate after 0123:0A0B, 4567:0A0B.
    do_start();
    wait_evt("nocand0");
    give_fb(0, 0);
    wait_evt("nocand1");
    chk("nocand_guess2", {16'b0, guess}, 32'h4567);
    chk("nocand_cnt2", {28'b0, guess_cnt}, 32'd2);
    give_fb(0, 0);
    wait_evt("nocand2");
    chk("nocand_fail", {31'b0, fail}, 32'd1);
    chk("nocand_gv", {31'b0, guess_valid}, 32'd0);

    // Illegal 3A1B feedback, then restart.
    do_start();
    wait_evt("ill0");
    give_fb(3, 1);
    chk("ill_fail", {31'b0, fail}, 32'd1);
    chk("ill_busy", {31'b0, busy}, 32'd0);
    do_start();
    tick();
    chk("ill_restart_guess", {16'b0, guess}, 32'h0123);
    chk("ill_restart_cnt", {28'b0, guess_cnt}, 32'd1);
    chk("ill_restart_gv", {31'b0, guess_valid}, 32'd1);

    // Start during SEARCH restarts with empty history.
    give_fb(1, 0);
    chk("srch_busy", {31'b0, busy}, 32'd1);
    chk("srch_gv", {31'b0, guess_valid}, 32'd0);
    do_start();
    tick();
    chk("srch_restart_guess", {16'b0, guess}, 32'h0123);
    chk("srch_restart_cnt", {28'b0, guess_cnt}, 32'd1);
    give_fb(0, 0);
    wait_evt("srch1");
    chk("srch_next_guess", {16'b0, guess}, 32'h4567);
    chk("srch_next_cnt", {28'b0, guess_cnt}, 32'd2);

    // Asynchronous reset during PROPOSE with feedback pending.
    fb_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_status", {28'b0, guess_valid, busy, solved, fail}, 32'd0);
    chk("arst_guess", {16'b0, guess}, 32'd0);
    chk("arst_cnt", {28'b0, guess_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    fb_valid = 1'b0;
    tick();
    tick();
    chk("arst_idle", {28'b0, guess_valid, busy, solved, fail}, 32'd0);
    do_start();
    wait_evt("arst0");
    chk("arst_first", {16'b0, guess}, 32'h0123);
    give_fb(0, 0);
    wait_evt("arst1");
    chk("arst_second", {16'b0, guess}, 32'h4567);
    chk("arst_second_cnt", {28'b0, guess_cnt}, 32'd2);

    // Random secrets with distinct digits.
    for (int g = 0; g < 3; g++) begin
      do secret = int'($urandom_range(2987, 123)); while (!distinct(secret));
      play(secret, $sformatf("rnd%0d", g));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
